// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma demodulator.
// Sample width, CIC order and the default decimation exponent live here,
// together with the helper that sizes the CIC datapath.
package dsm_pkg;

    localparam int DSM_DW           = 20;
    localparam int CIC_ORDER        = 3;
    localparam int DEFAULT_LOG2_DEC = 6;

    typedef logic [DSM_DW-1:0] dsm_sample_t;

    // Bits needed to hold the full-scale CIC gain R^N without loss.
    function automatic int cic_width(input int order, input int log2_dec);
        return order * log2_dec + 1;
    endfunction

endpackage

// File: rtl/dsm_cic_comb.sv
// One CIC comb stage: out = in - in(previous decimation tick).
// The delay register only advances on a decimation tick, so the stage
// runs at the output rate while the difference itself stays combinational.
module dsm_cic_comb
    import dsm_pkg::*;
#(
    parameter int W = cic_width(CIC_ORDER, DEFAULT_LOG2_DEC)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] delay;

    // Modulo-2^W difference; wrap in the integrators cancels out here.
    assign dout = din - delay;

    // Capture this stage's input once per decimation period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            delay <= '0;
        end else if (tick) begin
            delay <= din;
        end
    end

endmodule

// File: rtl/dsm_decimator.sv
// Third-order CIC (sinc^3) decimator for a 1-bit delta-sigma bitstream.
// Produces DW-bit samples at clock / 2^LOG2_DEC.
// Build option: define DSM_DEC_BIPOLAR_EN to emit two's-complement samples
// (unipolar result with MSB inverted); otherwise output is unsigned.
module dsm_decimator
    import dsm_pkg::*;
#(
    parameter int DW       = DSM_DW,
    parameter int LOG2_DEC = DEFAULT_LOG2_DEC,
    parameter int ORDER    = CIC_ORDER
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pwm,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          warm
);

    localparam int W   = cic_width(ORDER, LOG2_DEC);
    localparam int SH  = DW - ORDER * LOG2_DEC;
    localparam int WCW = $clog2(ORDER + 1);

    if (ORDER != CIC_ORDER) begin : g_bad_order
        $error("dsm_decimator: ORDER must be %0d", CIC_ORDER);
    end
    if (LOG2_DEC < 1 || 3 * LOG2_DEC > DW - 2) begin : g_bad_log2_dec
        $error("dsm_decimator: LOG2_DEC out of range");
    end

    logic [W-1:0]        i1, i2, i3;
    logic [LOG2_DEC-1:0] dec_cnt;
    logic                tick;
    logic [WCW-1:0]      warm_cnt;
    logic [DW:0]         s;
    logic [DW-1:0]       scaled;
    logic [DW-1:0]       result;
    logic [W-1:0]        c3;

    assign tick = &dec_cnt;

    // Pipelined integrators, each fed by the previous stage's registered value.
    // NOTE: non-blocking assignments make every stage read the pre-edge value
    // of its predecessor; blocking here would collapse the pipeline.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
        end else begin
            i1 <= i1 + {{(W-1){1'b0}}, pwm};
            i2 <= i2 + i1;
            i3 <= i3 + i2;
        end
    end

    // Free-running decimation counter; tick marks the last cycle of a window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dec_cnt <= '0;
        end else begin
            dec_cnt <= dec_cnt + 1'b1;
        end
    end

    // Comb chain: stage 0 reads the last integrator, each later stage the one before.
    for (genvar g = 0; g < ORDER; g++) begin : stage
        logic [W-1:0] din;
        logic [W-1:0] diff;
        if (g == 0) begin : g_first
            assign din = i3;
        end else begin : g_next
            assign din = stage[g-1].diff;
        end
        dsm_cic_comb #(.W(W)) u_comb (
            .clock (clock),
            .reset (reset),
            .tick  (tick),
            .din   (din),
            .dout  (diff)
        );
    end

    assign c3 = stage[ORDER-1].diff;
    assign s  = {c3, {SH{1'b0}}};

    // Scale full-scale R^N onto DW bits; the single overflow code saturates.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        scaled = s[DW-1:0];
        if (s[DW] && (s[DW-1:0] == '0)) begin
            scaled = '1;
        end
`ifdef DSM_DEC_BIPOLAR_EN
        result = {~scaled[DW-1], scaled[DW-2:0]};
`else
        result = scaled;
`endif
    end

    // Output register, valid strobe and warm-up tracking on decimation ticks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            warm       <= 1'b0;
            warm_cnt   <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (tick) begin
                dout <= result;
                if (warm_cnt == WCW'(ORDER)) begin
                    dout_valid <= 1'b1;
                    warm       <= 1'b1;
                end else begin
                    warm_cnt <= warm_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsm_decimator.sv
// Directed bench for dsm_decimator at default parameters (R = 64, DW = 20).
// Expected samples are hand-derived; the bipolar build flips the MSB.
module tb_dsm_decimator;
    import dsm_pkg::*;

`ifdef DSM_DEC_BIPOLAR_EN
    localparam logic [19:0] BIP = 20'h80000;
`else
    localparam logic [19:0] BIP = 20'h00000;
`endif

    localparam int K_ZERO    = 0;
    localparam int K_ONE     = 1;
    localparam int K_ALT     = 2;
    localparam int K_QUARTER = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [19:0] expect_u;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pwm   = 1'b0;
    logic [19:0] dout;
    logic        dout_valid;
    logic        warm;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dsm_decimator dut (
        .clock      (clock),
        .reset      (reset),
        .pwm        (pwm),
        .dout       (dout),
        .dout_valid (dout_valid),
        .warm       (warm)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit presented before rising edge e (e counts from 1 after reset release).
    function automatic logic pat(input int kind, input int e);
        case (kind)
            K_ONE:     return 1'b1;
            K_ALT:     return e[0];
            K_QUARTER: return (e % 4) == 0;
            default:   return 1'b0;
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        pwm   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        int early = 0;
        logic [19:0] exp = v.expect_u ^ BIP;
        apply_reset();
        for (int e = 1; e <= 400; e++) begin
            pwm = pat(v.kind, e);
            @(posedge clock);
            #1;
            if (e < 256 && dout_valid) early++;
            if (e == 255) check({v.name, " warm_before"}, 32'(warm), 32'd0);
            if (e == 256) begin
                check({v.name, " valid_256"}, 32'(dout_valid), 32'd1);
                check({v.name, " warm_256"},  32'(warm),       32'd1);
                check({v.name, " dout_256"},  32'(dout),       32'(exp));
            end
            if (e == 257) check({v.name, " valid_257"}, 32'(dout_valid), 32'd0);
            if (e == 300) check({v.name, " dout_hold"}, 32'(dout),       32'(exp));
            if (e == 320) begin
                check({v.name, " valid_320"}, 32'(dout_valid), 32'd1);
                check({v.name, " dout_320"},  32'(dout),       32'(exp));
            end
            if (e == 384) check({v.name, " dout_384"}, 32'(dout), 32'(exp));
        end
        check({v.name, " early_valids"}, 32'(early), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        int early;
        int nvalid;
        int badwrap;

        vecs[0] = '{name: "ones",    kind: K_ONE,     expect_u: 20'hFFFFF};
        vecs[1] = '{name: "zeros",   kind: K_ZERO,    expect_u: 20'h00000};
        vecs[2] = '{name: "alt",     kind: K_ALT,     expect_u: 20'h80000};
        vecs[3] = '{name: "quarter", kind: K_QUARTER, expect_u: 20'h40000};

        // Reset state while reset is held.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_dout",  32'(dout),       32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_warm",  32'(warm),       32'd0);

        foreach (vecs[i]) run_vector(vecs[i]);

        // Asynchronous reset 10 cycles after the 5th tick, then clean restart.
        apply_reset();
        for (int e = 1; e <= 330; e++) begin
            pwm = 1'b1;
            @(posedge clock);
            #1;
        end
        check("pre_abort_warm", 32'(warm), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_dout",  32'(dout),       32'd0);
        check("abort_valid", 32'(dout_valid), 32'd0);
        check("abort_warm",  32'(warm),       32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        early = 0;
        for (int e = 1; e <= 256; e++) begin
            pwm = pat(K_ALT, e);
            @(posedge clock);
            #1;
            if (e < 256 && dout_valid) early++;
            if (e == 256) begin
                check("restart_valid", 32'(dout_valid), 32'd1);
                check("restart_dout",  32'(dout),       32'(20'h80000 ^ BIP));
            end
        end
        check("restart_early_valids", 32'(early), 32'd0);

        // Long all-ones run: integrators wrap many times, output must not move.
        apply_reset();
        nvalid  = 0;
        badwrap = 0;
        for (int e = 1; e <= 10000; e++) begin
            pwm = 1'b1;
            @(posedge clock);
            #1;
            if (dout_valid) begin
                nvalid++;
                if (dout !== (20'hFFFFF ^ BIP)) begin
                    badwrap++;
                    if (badwrap <= 3) check("wrap_dout", 32'(dout), 32'(20'hFFFFF ^ BIP));
                end
            end
        end
        check("wrap_bad_samples", 32'(badwrap), 32'd0);
        check("wrap_valid_count", 32'(nvalid),  32'd153);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
